// File: rtl/issuer_if.sv
// Host/Control-facing signal bundle for instr_issuer: the host and the Control
// block drive the master side, the issuer drives the slave side.
interface issuer_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 8
);
  logic               run;
  logic               abort;
  logic [ADDR_W-1:0]  base_addr;
  logic [ADDR_W-1:0]  last_addr;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               ready;
  logic               wen;
  logic               start;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               done;
  logic               error;
  logic [CNT_W-1:0]   retired;

  modport master (
    output run, abort, base_addr, last_addr, load_en, load_addr, load_data, ready, wen,
    input  start, instr, pc, busy, done, error, retired
  );

  modport slave (
    input  run, abort, base_addr, last_addr, load_en, load_addr, load_data, ready, wen,
    output start, instr, pc, busy, done, error, retired
  );
endinterface

// File: rtl/instr_issuer.sv
// Issue-side sequencer: steps a small program memory through the Control block's
// Start/Ready/Wen handshake, counting retirements and guarding write-back with a watchdog.
module instr_issuer #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  issuer_if.slave  bus
);
  localparam int         WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB, DONE} state_t;

  state_t             state;
  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [WD_W-1:0]    wdog;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] instr;
  logic [CNT_W-1:0]   retired;
  logic               start;
  logic               busy;
  logic               done;
  logic               error;
  logic               loadable;

  assign loadable = (state == IDLE) || (state == DONE);
  assign pc_next  = pc + 1'b1;

  assign bus.start   = start;
  assign bus.instr   = instr;
  assign bus.pc      = pc;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.error   = error;
  assign bus.retired = retired;

  // NOTE: the program memory has no reset; its contents are undefined until loaded,
  // which keeps it a plain RAM with a single write port.
  always_ff @(posedge clk) begin
    if (bus.load_en && loadable) mem[bus.load_addr] <= bus.load_data;
  end

  // NOTE: all state updates are non-blocking, so a Run that coincides with a load
  // to base_addr reads the word that was in memory before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      pc      <= '0;
      instr   <= '0;
      retired <= '0;
      wdog    <= '0;
    end else if (bus.abort) begin
      // Abort leaves pc/retired/error visible for post-mortem.
      state <= IDLE;
      start <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.run) begin
            pc      <= bus.base_addr;
            instr   <= mem[bus.base_addr];
            retired <= '0;
            error   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr[INSTR_W-1 -: 4] == OP_HALT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (bus.ready) begin
            start <= 1'b1;
            wdog  <= '0;
            state <= WAIT_WB;
          end
        end
        WAIT_WB: begin
          wdog <= wdog + 1'b1;
          if (bus.wen) begin
            if (retired != '1) retired <= retired + 1'b1;
            if (pc == bus.last_addr) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pc    <= pc_next;
              instr <= mem[pc_next];
              state <= ISSUE;
            end
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            // Error becomes visible exactly TIMEOUT cycles after the Start pulse.
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: a cycle-accurate Control stand-in, a table of directed
// programs, hand-written corner sequences and randomized programs against a reference model.
module tb_instr_issuer;
  logic clk;
  logic rst_n;

  issuer_if #(.ADDR_W(4), .INSTR_W(16), .CNT_W(8)) bus ();

  instr_issuer #(.ADDR_W(4), .INSTR_W(16), .TIMEOUT(15), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pc;
    logic [15:0] instr;
  } start_rec_t;

  typedef struct {
    logic [3:0] base;
    logic [3:0] last;
    bit         poke;
    int         n;
    logic [3:0] fpc;
    logic [7:0] ret;
  } vec_t;

  int          tests;
  int          fails;
  int          cyc;
  int          run_cyc;
  int          n;
  bit          ctl_hang;
  start_rec_t  starts[$];
  logic [15:0] shadow[16];
  logic [15:0] img[16] = '{16'h1000, 16'h2001, 16'h3002, 16'hF003, 16'h4004, 16'h5005,
                           16'h6006, 16'h7007, 16'h8008, 16'h9009, 16'hA00A, 16'hB00B,
                           16'hC00C, 16'hD00D, 16'hE00E, 16'h100F};
  vec_t        vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control stand-in: Ready in S0; after Start, S1..S4 then Wen in the fifth cycle.
  initial begin
    int cnt;
    cnt = 0;
    bus.ready = 1'b1;
    bus.wen   = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n)            cnt = 0;
      else if (ctl_hang)     cnt = 0;
      else if (cnt == 0)     cnt = bus.start ? 1 : 0;
      else                   cnt = (cnt == 6) ? 0 : cnt + 1;
      bus.ready = ctl_hang || (cnt == 0);
      bus.wen   = !ctl_hang && (cnt == 6);
    end
  end

  initial begin
    cyc = 0;
    run_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.run)   run_cyc = cyc;
      if (bus.start) starts.push_back('{cyc, bus.pc, bus.instr});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.load_en = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!bus.start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", bus.start, 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", bus.done, 1);
  endtask

  task automatic launch(input logic [3:0] b, input logic [3:0] l);
    starts.delete();
    @(negedge clk);
    bus.base_addr = b;
    bus.last_addr = l;
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
  endtask

  // Reference: walk from base, stop on HALT (not counted) or after retiring last.
  task automatic model_run(input logic [3:0] b, input logic [3:0] l,
                           output int cnt, output logic [3:0] fpc);
    logic [3:0] a;
    a = b;
    cnt = 0;
    for (int k = 0; k < 17; k++) begin
      if (shadow[a][15:12] == 4'hF) break;
      cnt++;
      if (a == l) break;
      a = a + 4'd1;
    end
    fpc = a;
  endtask

  task automatic run_check(input logic [3:0] b, input logic [3:0] l, input bit poke,
                           input int e_n, input logic [3:0] e_pc, input logic [7:0] e_ret);
    launch(b, l);
    if (poke) begin
      wait_start();
      // Write attempt while in WAIT_WB; shadow is deliberately left unchanged.
      @(negedge clk);
      bus.load_en = 1'b1;
      bus.load_addr = 4'd15;
      bus.load_data = 16'hBEEF;
      @(negedge clk);
      bus.load_en = 1'b0;
    end
    wait_done();
    repeat (2) @(negedge clk);
    check("start_count", starts.size(), e_n);
    for (int i = 0; i < starts.size() && i < e_n; i++) begin
      logic [3:0] ep;
      ep = b + 4'(i);
      check("start_pc", starts[i].pc, ep);
      check("start_instr", starts[i].instr, shadow[starts[i].pc]);
      if (i == 0) check("first_start_latency", starts[0].cyc - run_cyc, 1);
      else        check("start_spacing", starts[i].cyc - starts[i-1].cyc, 7);
    end
    check("end_done", bus.done, 1);
    check("end_busy", bus.busy, 0);
    check("end_error", bus.error, 0);
    check("end_start", bus.start, 0);
    check("end_retired", bus.retired, e_ret);
    check("end_pc", bus.pc, e_pc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, bus.start, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_error"}, bus.error, 0);
    check({tag, "_pc"}, bus.pc, 0);
    check({tag, "_instr"}, bus.instr, 0);
    check({tag, "_retired"}, bus.retired, 0);
  endtask

  initial begin
    int         rn;
    logic [3:0] rb, rl, rpc;
    tests = 0;
    fails = 0;
    ctl_hang = 1'b0;
    bus.run = 1'b0;
    bus.abort = 1'b0;
    bus.base_addr = '0;
    bus.last_addr = '0;
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) load(4'(a), img[a]);

    vecs[0] = '{4'd0,  4'd2, 1'b0, 3, 4'd2, 8'd3};
    vecs[1] = '{4'd0,  4'd5, 1'b0, 3, 4'd3, 8'd3};
    vecs[2] = '{4'd14, 4'd1, 1'b1, 4, 4'd1, 8'd4};
    vecs[3] = '{4'd4,  4'd4, 1'b0, 1, 4'd4, 8'd1};
    vecs[4] = '{4'd3,  4'd7, 1'b0, 0, 4'd3, 8'd0};
    vecs[5] = '{4'd10, 4'd2, 1'b0, 9, 4'd2, 8'd9};
    for (int v = 0; v < 6; v++)
      run_check(vecs[v].base, vecs[v].last, vecs[v].poke, vecs[v].n, vecs[v].fpc, vecs[v].ret);

    // Watchdog: Control accepts Start but never writes back.
    ctl_hang = 1'b1;
    launch(4'd0, 4'd2);
    wait_start();
    n = 0;
    while (!bus.error && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wd_error_latency", n, 15);
    check("wd_done", bus.done, 1);
    check("wd_busy", bus.busy, 0);
    check("wd_retired", bus.retired, 0);
    ctl_hang = 1'b0;
    launch(4'd0, 4'd2);
    check("wd_error_cleared", bus.error, 0);
    check("wd_done_cleared", bus.done, 0);
    wait_done();
    check("wd_rerun_retired", bus.retired, 3);
    check("wd_rerun_error", bus.error, 0);
    repeat (2) @(negedge clk);

    // Abort in WAIT_WB; the controller's late Wen must be ignored.
    launch(4'd0, 4'd2);
    wait_start();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_start", bus.start, 0);
    check("abort_done", bus.done, 0);
    repeat (8) @(negedge clk);
    check("abort_retired", bus.retired, 0);
    check("abort_pc", bus.pc, 0);
    check("abort_starts", starts.size(), 1);
    check("abort_idle", bus.busy, 0);

    // Asynchronous reset while waiting for write-back.
    launch(4'd1, 4'd2);
    wait_start();
    @(negedge clk);
    check("rst_pre_busy", bus.busy, 1);
    check("rst_pre_pc", bus.pc, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_post_busy", bus.busy, 0);
    check("rst_post_done", bus.done, 0);
    check("rst_post_starts", starts.size(), 1);

    // HALT after one real instruction.
    load(4'd0, 16'h1111);
    load(4'd1, 16'hF000);
    run_check(4'd0, 4'd5, 1'b0, 1, 4'd1, 8'd1);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 5) == 0) w[15:12] = 4'hF;
        load(4'(a), w);
      end
      rb = 4'($urandom);
      rl = 4'($urandom);
      model_run(rb, rl, rn, rpc);
      run_check(rb, rl, 1'b0, rn, rpc, 8'(rn));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Issue-side sequencer that drives the Start/Ready/Wen handshake of the processor Control block.
- Holds a small writable program memory and presents one instruction word at a time on Instr.
- Pulses Start when the controller reports Ready, then waits for the Wen write-back pulse before advancing PC.
- Sits between the test/host load interface and the Control + datapath pair. Tracks retired instructions, HALT, and a write-back watchdog.

Parameters:
ADDR_W, 4, program memory address width (depth 2**ADDR_W)
INSTR_W, 16, instruction word width; opcode is Instr[INSTR_W-1:INSTR_W-4]
TIMEOUT, 15, max cycles in WAIT_WB without Wen before Error
CNT_W, 8, width of retired-instruction counter

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
Run  in  1  begin execution from address Base_addr (sampled in IDLE/DONE)
Abort  in  1  synchronous abort to IDLE, highest priority after reset
Base_addr  in  ADDR_W  first instruction address
Last_addr  in  ADDR_W  last instruction address (inclusive)
Load_en  in  1  program memory write enable
Load_addr  in  ADDR_W  program memory write address
Load_data  in  INSTR_W  program memory write data
Ready  in  1  controller idle (from Control)
Wen  in  1  controller write-back pulse (from Control)
Start  out  1  one-cycle instruction start pulse (to Control)
Instr  out  INSTR_W  current instruction word, stable from Start until Wen sampled
PC  out  ADDR_W  address of current instruction
Busy  out  1  high in ISSUE/WAIT_WB
Done  out  1  high in DONE
Error  out  1  sticky watchdog flag, cleared by next Run or reset
Retired  out  CNT_W  instructions retired since last Run, saturates at all-ones

Behaviour:
- Reset (RST_N=0, async): state IDLE; Start, Busy, Done, Error = 0; PC = 0; Instr = 0; Retired = 0; watchdog = 0. Memory contents are not reset.
- All outputs are registered.
- Memory write: on a CLK edge with Load_en=1 and state IDLE or DONE, mem[Load_addr] <= Load_data. Writes are ignored in ISSUE/WAIT_WB.
- States: IDLE, ISSUE, WAIT_WB, DONE.
- IDLE/DONE + Run=1:
  - PC <= Base_addr; Instr <= mem[Base_addr]; Retired <= 0; Error <= 0; Done <= 0; go to ISSUE.
  - If Load_en writes Base_addr on the same edge, the old word is loaded.
- ISSUE:
  - If the Instr opcode is 4'hF (HALT): no Start; go to DONE; HALT is not counted.
  - Else if Ready=1 sampled: Start <= 1 for exactly one cycle; watchdog <= 0; go to WAIT_WB.
  - Else: hold.
- WAIT_WB:
  - Start <= 0; watchdog increments each cycle.
  - On Wen=1: Retired <= Retired+1 (saturating).
    - If PC == Last_addr: go to DONE.
    - Else PC <= PC+1 (wraps mod 2**ADDR_W); Instr <= mem[PC+1]; go to ISSUE.
  - If watchdog reaches TIMEOUT with no Wen: Error <= 1; go to DONE.
  - Wen outside WAIT_WB is ignored.
- DONE: Done=1, holds PC/Instr/Retired until Run or Abort.
- Abort=1 in any state: Start <= 0; go to IDLE; Done <= 0; PC/Retired/Error hold.
  - A controller already past S0 finishes its own sequence; its Wen is ignored.
- Run during ISSUE/WAIT_WB is ignored.
- Timing with Control:
  - Start high in cycle k.
  - Control is in S1–S4 for cycles k+1..k+4; Wen is high in cycle k+5.
  - Issuer samples Wen at the end of k+5 and re-enters ISSUE.
  - Next Start is in cycle k+7.
  - Steady state: one instruction per 7 cycles.
- Wrap: Base_addr > Last_addr is legal. PC wraps through 2**ADDR_W-1 to 0 until it equals Last_addr.

Test Plan:
- Reset mid-run:
  - Stimulus: load 3 instructions, Run, assert RST_N=0 while in WAIT_WB.
  - Response: all outputs are 0 immediately (async), without waiting for CLK; state IDLE after release.
- Basic program:
  - Stimulus: mem[0..2] = 16'h1000,16'h2001,16'h3002; Base_addr=0, Last_addr=2; Run, paired with Control.
  - Response: exactly 3 Start pulses spaced 7 cycles apart; Instr matches each word during its Start; Done=1, Retired=3, PC=2, Error=0.
- HALT:
  - Stimulus: mem[0]=16'h1111, mem[1]=16'hF000; Last_addr=5.
  - Response: 1 Start pulse; DONE entered with PC=1, Retired=1.
- Watchdog:
  - Stimulus: Ready held 1 and Wen held 0 after Start.
  - Response: Error=1 and Done=1 exactly TIMEOUT=15 cycles after Start; next Run clears Error.
- Wrap and write lockout:
  - Stimulus: Base_addr=14, Last_addr=1; a Load_en write to address 15 during WAIT_WB.
  - Response: PC sequence is 14,15,0,1 and Retired=4; mem[15] still holds its old value (check Instr when PC=15).
- Abort:
  - Stimulus: Abort in WAIT_WB.
  - Response: IDLE next cycle with Start=0; the late Wen from Control does not increment Retired.
